// File: rtl/mult_booth_unit.sv
// Sequential 32x32 signed multiplier, radix-2 Booth, one iteration per clock.
// Product and overflow come straight from the {A,Q} registers.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | 32 Booth add/sub/nop + arithmetic-shift iterations
// DONE  | one-cycle ready; product valid, start may relaunch
module mult_booth_unit (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [63:0] product,
  output logic        overflow,
  output logic        busy,
  output logic        ready,
  output logic        add,
  output logic        sub,
  output logic        nop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [32:0] acc;
  logic [31:0] q_reg;
  logic [31:0] m_reg;
  logic        q_m1;
  logic [5:0]  cnt;
  logic        accept;
  logic [32:0] m_ext;
  logic [32:0] sum;

  assign m_ext = {m_reg[31], m_reg};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    add       = 1'b0;
    sub       = 1'b0;
    nop       = 1'b0;
    sum       = acc;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        case ({q_reg[0], q_m1})
          2'b01:   begin add = 1'b1; sum = acc + m_ext; end
          2'b10:   begin sub = 1'b1; sum = acc - m_ext; end
          default: nop = 1'b1;
        endcase
        if (cnt == 6'd31) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      acc   <= '0;
      q_reg <= '0;
      m_reg <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        m_reg <= multiplicand;
        q_reg <= multiplier;
        acc   <= '0;
        q_m1  <= 1'b0;
        cnt   <= '0;
      end else if (state == RUN) begin
        // arithmetic shift of {sum, Q, Q_-1}; sign taken from the 33-bit sum
        acc   <= {sum[32], sum[32:1]};
        q_reg <= {sum[0], q_reg[31:1]};
        q_m1  <= q_reg[0];
        cnt   <= cnt + 6'd1;
      end
    end
  end

  assign product  = {acc[31:0], q_reg};
  assign overflow = ~((&product[63:31]) | ~(|product[63:31]));
  assign busy     = (state == RUN);
  assign ready    = (state == DONE);

endmodule

// File: tb/tb_mult_booth_unit.sv
// Directed-vector bench for mult_booth_unit: latency, products, overflow,
// Booth strobes, ignored restart, back-to-back launch and mid-run reset.
module tb_mult_booth_unit;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] product;
  logic        overflow;
  logic        busy;
  logic        ready;
  logic        add;
  logic        sub;
  logic        nop;

  int n_chk = 0;
  int n_err = 0;
  int n_busy;
  logic [2:0] strb_log [0:39];

  mult_booth_unit dut (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .overflow     (overflow),
    .busy         (busy),
    .ready        (ready),
    .add          (add),
    .sub          (sub),
    .nop          (nop)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Raise start for one edge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [31:0] m, input logic [31:0] q);
    @(negedge clock);
    start = 1'b1;
    multiplicand = m;
    multiplier = q;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; returns in the DONE cycle.
  task automatic wait_ready(input int poke_at, output int cyc);
    cyc = 0;
    n_busy = 0;
    for (int i = 0; i < 40; i++) strb_log[i] = 3'b000;
    while (!ready && cyc < 100) begin
      if (busy) n_busy++;
      if (cyc < 40) strb_log[cyc] = {add, sub, nop};
      if (cyc == poke_at) begin
        start = 1'b1;
        multiplicand = 32'd100;
        multiplier = 32'd77;
      end else if (poke_at >= 0 && cyc == poke_at + 1) begin
        start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    if (!ready) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_done(input string tag, input int cyc,
                            input logic [63:0] exp_prod, input logic exp_ovf);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (!$onehot(strb_log[i])) bad++;
    chk({tag, "_latency"}, 64'(cyc), 64'd32);
    chk({tag, "_busy_cycles"}, 64'(n_busy), 64'd32);
    chk({tag, "_strobe_onehot"}, 64'(bad), 64'd0);
    chk({tag, "_product"}, product, exp_prod);
    chk({tag, "_overflow"}, {63'd0, overflow}, {63'd0, exp_ovf});
    chk({tag, "_done_idle"}, {61'd0, busy, add | sub | nop, ready}, 64'd1);
  endtask

  task automatic do_mul(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input logic [63:0] exp_prod, input logic exp_ovf);
    int cyc;
    launch(m, q);
    wait_ready(-1, cyc);
    check_done(tag, cyc, exp_prod, exp_ovf);
    @(negedge clock);
    chk({tag, "_ready_width"}, {63'd0, ready}, 64'd0);
    chk({tag, "_held"}, product, exp_prod);
  endtask

  initial begin
    int   cyc;
    int   nonop;
    int   rdy_seen;
    time  t1, t2;

    resetn = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(negedge clock);
    chk("rst_product", product, 64'd0);
    chk("rst_flags", {58'd0, overflow, busy, ready, add, sub, nop}, 64'd0);
    resetn = 1'b1;

    do_mul("p3x5", 32'd3, 32'd5, 64'd15, 1'b0);
    do_mul("m7x6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
    do_mul("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    do_mul("maxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1);
    do_mul("m1x1", 32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000, 1'b1);

    // Strobe sequence for M=9, Q=1: sub, add, then 30 nops
    launch(32'd9, 32'd1);
    wait_ready(-1, cyc);
    check_done("s9x1", cyc, 64'd9, 1'b0);
    chk("s9x1_first_sub", {61'd0, strb_log[0]}, 64'b010);
    chk("s9x1_second_add", {61'd0, strb_log[1]}, 64'b100);
    nonop = 0;
    for (int i = 2; i < 32; i++)
      if (strb_log[i] != 3'b001) nonop++;
    chk("s9x1_rest_nop", 64'(nonop), 64'd0);

    // Restart during RUN is ignored; restart in DONE is accepted
    launch(32'd3, 32'd5);
    wait_ready(10, cyc);
    check_done("ignore", cyc, 64'd15, 1'b0);
    t1 = $time;
    start = 1'b1;
    multiplicand = 32'd2;
    multiplier = 32'd4;
    @(negedge clock);
    start = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    wait_ready(-1, cyc);
    t2 = $time;
    check_done("b2b", cyc, 64'd8, 1'b0);
    chk("b2b_spacing", 64'((t2 - t1) / 10), 64'd33);

    // Reset at iteration 20 aborts without ready
    launch(32'd3, 32'd5);
    repeat (20) @(negedge clock);
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    resetn = 1'b0;
    #1;
    chk("async_rst_product", product, 64'd0);
    chk("async_rst_flags", {58'd0, overflow, busy, ready, add, sub, nop}, 64'd0);
    #3;
    resetn = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ready || busy) rdy_seen++;
    end
    chk("no_ready_after_rst", 64'(rdy_seen), 64'd0);
    do_mul("post_rst", 32'd3, 32'd5, 64'd15, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
